// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: steps green/yellow/red phases,
// serves latched pedestrian requests and parks in flashing yellow on request.
module traffic_phase_ctrl #(
  parameter int pRed_Count_Sec    = 18,
  parameter int pYellow_Count_Sec = 3,
  parameter int pGreen_Count_Sec  = 15,
  parameter int pPed_Count_Sec    = 10,
  parameter int pCount_width      = $clog2(pRed_Count_Sec)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    sec_tick,
  input  logic                    light_tick,
  input  logic                    ped_req,
  input  logic                    flash_req,
  output logic                    ctr_en,
  output logic                    ctr_load,
  output logic [pCount_width-1:0] load_count,
  output logic [2:0]              main_rgy,
  output logic [2:0]              side_rgy,
  output logic                    ped_walk,
  output logic                    ped_pend,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_SG    = 3'd2,
    S_SY    = 3'd3,
    S_PED   = 3'd4,
    S_FLASH = 3'd5
  } state_e;

  localparam logic [pCount_width-1:0] GREEN_LD  = pCount_width'(pGreen_Count_Sec - 1);
  localparam logic [pCount_width-1:0] YELLOW_LD = pCount_width'(pYellow_Count_Sec - 1);
  localparam logic [pCount_width-1:0] PED_LD    = pCount_width'(pPed_Count_Sec - 1);

  state_e state_q, state_d, target;
  logic   ped_pend_q, ped_pend_d;
  logic   flash_on_q, flash_on_d;
  logic   ctr_en_q, ctr_en_d;
  logic   adv;

  // Flash mode borrows the green value so the counter sits ready for S_MG.
  function automatic logic [pCount_width-1:0] dur_m1(input state_e s);
    case (s)
      S_MY, S_SY: dur_m1 = YELLOW_LD;
      S_PED:      dur_m1 = PED_LD;
      default:    dur_m1 = GREEN_LD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    if (state_q == S_FLASH) begin
      if (sec_tick && !flash_req) state_d = S_MG;
    end else if (light_tick) begin
      adv = 1'b1;
      if (flash_req) begin
        state_d = S_FLASH;
      end else begin
        case (state_q)
          S_MG:    state_d = S_MY;
          S_MY:    state_d = S_SG;
          S_SG:    state_d = S_SY;
          S_SY:    state_d = ped_pend_q ? S_PED : S_MG;
          default: state_d = S_MG;
        endcase
      end
    end

    // Entering S_PED clears the request even if a new one arrives this cycle.
    ped_pend_d = (adv && state_d == S_PED) ? 1'b0 : (ped_pend_q | ped_req);
    flash_on_d = (state_q == S_FLASH && state_d == S_FLASH) ? (flash_on_q ^ sec_tick) : 1'b0;
    ctr_en_d   = 1'b1;

    target     = (state_q == S_FLASH) ? S_MG : state_d;
    load_count = dur_m1(target);
    ctr_load   = (state_q == S_FLASH) ? sec_tick : light_tick;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_MG;
      ped_pend_q <= 1'b0;
      flash_on_q <= 1'b0;
      ctr_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      flash_on_q <= flash_on_d;
      ctr_en_q   <= ctr_en_d;
    end
  end

  always_comb begin
    main_rgy = 3'b100;
    side_rgy = 3'b100;
    ped_walk = 1'b0;
    case (state_q)
      S_MG:    main_rgy = 3'b001;
      S_MY:    main_rgy = 3'b010;
      S_SG:    side_rgy = 3'b001;
      S_SY:    side_rgy = 3'b010;
      S_PED:   ped_walk = 1'b1;
      S_FLASH: begin
        main_rgy = {1'b0, flash_on_q, 1'b0};
        side_rgy = {1'b0, flash_on_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign ctr_en   = ctr_en_q;
  assign ped_pend = ped_pend_q;
  assign phase    = state_q;

endmodule
